mips_avalon_master: RTL and testbench
=====================================

MIPS_AVALON_MASTER -- requirements
Module: mips_avalon_master

Interface
REQ-001 Parameter TIMEOUT, default 64, SHALL be the maximum number of cycles a bus transaction may stall before it is aborted.
REQ-002 clk  in  1  SHALL be the single clock; every register updates on its rising edge.
REQ-003 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-004 start  in  1  SHALL be the CPU request strobe, sampled only in IDLE.
REQ-005 req_write  in  1  SHALL select the operation: 1 is store, 0 is load.
REQ-006 req_size  in  2  SHALL encode the access size: 00 byte, 01 half, 10 word; 11 is illegal.
REQ-007 req_signed  in  1  SHALL select sign extension (1) or zero extension (0) for byte/half loads.
REQ-008 req_addr  in  32  SHALL be the CPU byte address.
REQ-009 req_wdata  in  32  SHALL carry store data, right-justified.
REQ-010 busy  out  1  SHALL be high in every state other than IDLE.
REQ-011 done  out  1  SHALL be a 1-cycle pulse on successful completion.
REQ-012 err  out  1  SHALL be a 1-cycle pulse on a misaligned access, illegal size, or timeout.
REQ-013 rdata  out  32  SHALL hold the extended load result, valid when done is high and held until the next accepted start.
REQ-014 address  out  32  SHALL be the Avalon word address, always with bits [1:0] = 00.
REQ-015 read / write  out  1 each  SHALL be the Avalon read and write strobes, never asserted together.
REQ-016 writedata  out  32  SHALL be store data shifted onto the selected byte lanes.
REQ-017 byteenable  out  4  SHALL be the Avalon byte lane enables.
REQ-018 waitrequest  in  1  SHALL be the slave stall signal.
REQ-019 readdata  in  32  SHALL be the slave read data.

Function
REQ-020 The block SHALL implement states IDLE, BUS, RESP and ERR.
REQ-021 IDLE + start SHALL transition as follows:
- misaligned access or size 11: go to ERR;
- otherwise: register address = {req_addr[31:2],2'b00}, byteenable, writedata and the load extraction controls, then go to BUS.
- Misaligned means a half at an odd address, or a word with addr[1:0] != 0.
REQ-022 Byte lanes SHALL be little-endian, with lane k equal to bits [8k+7:8k].
- byte access: byteenable = 1 << addr[1:0];
- half access: byteenable = 0011 (addr[1]=0) or 1100 (addr[1]=1);
- word access: byteenable = 1111;
- writedata = req_wdata << (8*addr[1:0]).
REQ-023 In BUS, read (load) or write (store) SHALL be high, and address, byteenable and writedata SHALL be held constant for the whole state.
REQ-024 The transaction SHALL complete on the first rising edge in BUS with waitrequest = 0.
- readdata SHALL be sampled on that same edge.
- Strobes SHALL deassert and the FSM SHALL go to RESP.
REQ-025 RESP SHALL last exactly one cycle, with done = 1, and then return to IDLE.
- Minimum latency from the start edge to done high SHALL be 2 cycles when waitrequest is low during the first BUS cycle.
REQ-026 Load extraction SHALL shift readdata right by 8*addr[1:0], take 8 or 16 bits, and sign- or zero-extend per req_signed; a word load SHALL pass all 32 bits unchanged.
REQ-027 A stall counter SHALL reset to 0 on BUS entry and increment on every BUS cycle with waitrequest = 1.
- When the counter reaches TIMEOUT, strobes SHALL drop and the FSM SHALL go to ERR.
REQ-028 ERR SHALL last one cycle, with err = 1, done = 0 and rdata unchanged, and then return to IDLE.
REQ-029 start SHALL be ignored while busy = 1; a start in the same cycle that RESP or ERR is active SHALL NOT be accepted.
REQ-030 A start in IDLE SHALL set busy = 1 in the following cycle.
REQ-031 Strobes SHALL be driven from registers only, with no combinational path from start to read or write.

Reset
REQ-032 On reset, the FSM SHALL go to IDLE, and read, write, done, err, busy and the stall counter SHALL all be 0.
REQ-033 On reset, address, writedata, byteenable and rdata SHALL be 0.
REQ-034 Reset asserted during BUS SHALL drop read and write at that edge, with no done or err pulse and no write completion.

Verification
REQ-035 Word load at 0xBFC00000, slave waitrequest high for 2 cycles, readdata 0x12345678 -> read held for 3 cycles, done pulse, rdata = 0x12345678, byteenable = 1111.
REQ-036 Byte store at 0x00000005 with req_wdata 0x000000AB -> address 0x4, byteenable 0010, writedata 0x0000AB00, done after waitrequest drops.
REQ-037 Signed half load at 0x00000002, readdata 0x8001BEEF -> rdata 0xFFFF8001; the same access unsigned -> rdata 0x00008001.
REQ-038 Word load at 0x00000006 -> err pulse 1 cycle after start, read and write never asserted, done = 0.
REQ-039 Store with waitrequest held high -> write held for TIMEOUT cycles, then dropped, err pulse, FSM returns to IDLE.
REQ-040 Reset pulsed in the 2nd BUS cycle of a load -> read = 0 on the next cycle, busy = 0, no done, and a new start is accepted afterwards.

Source files
------------

// File: rtl/mips_avalon_master.sv
// Bridges a single-access MIPS-style load/store request onto an Avalon-MM master port,
// handling byte-lane steering, load extension, stall timeout and alignment errors.
module mips_avalon_master #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  // CPU side
  input  logic        start,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  // Avalon-MM side
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBus  = 2'd1;
  localparam logic [1:0] StResp = 2'd2;
  localparam logic [1:0] StErr  = 2'd3;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            read_q, read_d;
  logic            write_q, write_d;
  logic [31:0]     address_q, address_d;
  logic [31:0]     writedata_q, writedata_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     rdata_q, rdata_d;
  // Load extraction controls captured at request time
  logic [1:0]      lane_q, lane_d;
  logic [1:0]      size_q, size_d;
  logic            signed_q, signed_d;

  logic            req_illegal;
  logic [3:0]      req_be;
  logic [31:0]     load_shifted;
  logic [31:0]     load_ext;
  logic [CntW-1:0] cnt_inc;
  logic            timeout_hit;

  // Request decode: alignment check and lane enables
  always_comb begin
    req_illegal = 1'b0;
    req_be      = 4'b0000;
    case (req_size)
      SizeByte: req_be = 4'b0001 << req_addr[1:0];
      SizeHalf: begin
        req_be      = req_addr[1] ? 4'b1100 : 4'b0011;
        req_illegal = req_addr[0];
      end
      SizeWord: begin
        req_be      = 4'b1111;
        req_illegal = (req_addr[1:0] != 2'b00);
      end
      default: req_illegal = 1'b1;
    endcase
  end

  // Load extraction from the live readdata, sampled into rdata on the completing edge
  always_comb begin
    load_shifted = readdata >> {lane_q, 3'b000};
    load_ext     = readdata;
    case (size_q)
      SizeByte: load_ext = {{24{signed_q & load_shifted[7]}}, load_shifted[7:0]};
      SizeHalf: load_ext = {{16{signed_q & load_shifted[15]}}, load_shifted[15:0]};
      default:  load_ext = readdata;
    endcase
  end

  assign cnt_inc     = cnt_q + CntW'(1);
  assign timeout_hit = (cnt_inc == CntW'(TIMEOUT));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    read_d      = read_q;
    write_d     = write_q;
    address_d   = address_q;
    writedata_d = writedata_q;
    be_d        = be_q;
    rdata_d     = rdata_q;
    lane_d      = lane_q;
    size_d      = size_q;
    signed_d    = signed_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          if (req_illegal) begin
            state_d = StErr;
          end else begin
            state_d     = StBus;
            cnt_d       = '0;
            read_d      = ~req_write;
            write_d     = req_write;
            address_d   = {req_addr[31:2], 2'b00};
            writedata_d = req_wdata << {req_addr[1:0], 3'b000};
            be_d        = req_be;
            lane_d      = req_addr[1:0];
            size_d      = req_size;
            signed_d    = req_signed;
          end
        end
      end
      StBus: begin
        if (!waitrequest) begin
          state_d = StResp;
          read_d  = 1'b0;
          write_d = 1'b0;
          if (read_q) begin
            rdata_d = load_ext;
          end
        end else begin
          cnt_d = cnt_inc;
          if (timeout_hit) begin
            state_d = StErr;
            read_d  = 1'b0;
            write_d = 1'b0;
          end
        end
      end
      StResp:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      address_q   <= '0;
      writedata_q <= '0;
      be_q        <= '0;
      rdata_q     <= '0;
      lane_q      <= '0;
      size_q      <= '0;
      signed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      read_q      <= read_d;
      write_q     <= write_d;
      address_q   <= address_d;
      writedata_q <= writedata_d;
      be_q        <= be_d;
      rdata_q     <= rdata_d;
      lane_q      <= lane_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StResp);
  assign err        = (state_q == StErr);
  assign rdata      = rdata_q;
  assign address    = address_q;
  assign read       = read_q;
  assign write      = write_q;
  assign writedata  = writedata_q;
  assign byteenable = be_q;

endmodule

// File: tb/tb_mips_avalon_master.sv
// Randomized self-checking bench for mips_avalon_master; a transaction-level model predicts
// lane enables, store data, load results and the done/err timing of each request.
module tb_mips_avalon_master;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  mips_avalon_master #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .rdata       (rdata),
    .address     (address),
    .read        (read),
    .write       (write),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .waitrequest (waitrequest),
    .readdata    (readdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  function automatic bit model_illegal(input logic [1:0] sz, input logic [31:0] a);
    int unsigned off = a % 4;
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1 && (off % 2) != 0) return 1'b1;
    if (sz == 2'd2 && off != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
    int unsigned off = a % 4;
    if (sz == 2'd0) return 4'(1 << off);
    if (sz == 2'd1) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  // Little-endian extraction done with plain arithmetic on the slave word
  function automatic logic [31:0] model_load(input logic [1:0] sz, input bit sg,
                                             input logic [31:0] a, input logic [31:0] rd);
    int unsigned off = a % 4;
    logic [31:0] v = rd / (32'd1 << (8 * off));
    if (sz == 2'd0) begin
      v = v % 256;
      if (sg && v >= 128) v = v - 32'd256;
    end else if (sz == 2'd1) begin
      v = v % 65536;
      if (sg && v >= 32768) v = v - 32'd65536;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // Junk request on the CPU side; must be ignored while busy
  task automatic drive_noise();
    start      = 1'($urandom_range(0, 1));
    req_write  = 1'($urandom_range(0, 1));
    req_size   = 2'($urandom_range(0, 3));
    req_signed = 1'($urandom_range(0, 1));
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  task automatic run_txn(input bit wr, input logic [1:0] sz, input bit sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int nwait, input logic [31:0] rd);
    bit          bad = model_illegal(sz, a);
    logic [3:0]  exp_be = model_be(sz, a);
    logic [31:0] exp_wd = wd * (32'd1 << (8 * (a % 4)));
    int          cyc = 0;
    bit          fin = 1'b0;

    check("idle_busy", busy, 0);
    start       = 1'b1;
    req_write   = wr;
    req_size    = sz;
    req_signed  = sg;
    req_addr    = a;
    req_wdata   = wd;
    waitrequest = 1'b1;
    readdata    = $urandom;
    @(negedge clk);
    start = 1'b0;

    if (bad) begin
      check("err_pulse", err, 1);
      check("err_done", done, 0);
      check("err_read", read, 0);
      check("err_write", write, 0);
      check("err_busy", busy, 1);
      check("err_rdata", rdata, exp_rdata);
      drive_noise();
      @(negedge clk);
      start = 1'b0;
      check("err_end", err, 0);
      check("err_idle", busy, 0);
      return;
    end

    while (!fin) begin
      check("bus_read", read, !wr);
      check("bus_write", write, wr);
      check("bus_busy", busy, 1);
      check("bus_done", done, 0);
      check("bus_err", err, 0);
      check("bus_addr", address, {a[31:2], 2'b00});
      check("bus_be", byteenable, exp_be);
      if (wr) check("bus_wdata", writedata, exp_wd);
      waitrequest = (cyc < nwait);
      readdata    = waitrequest ? $urandom : rd;
      drive_noise();
      @(negedge clk);
      cyc++;
      if (cyc > nwait) begin
        if (!wr) exp_rdata = model_load(sz, sg, a, rd);
        check("resp_done", done, 1);
        check("resp_err", err, 0);
        check("resp_rdata", rdata, exp_rdata);
        check("resp_strobes", {read, write}, 0);
        fin = 1'b1;
      end else if (cyc == TO) begin
        check("tmo_err", err, 1);
        check("tmo_done", done, 0);
        check("tmo_rdata", rdata, exp_rdata);
        check("tmo_strobes", {read, write}, 0);
        fin = 1'b1;
      end
    end

    waitrequest = 1'b0;
    drive_noise();
    @(negedge clk);
    start = 1'b0;
    check("post_busy", busy, 0);
    check("post_done", done, 0);
    check("post_err", err, 0);
    check("post_rdata", rdata, exp_rdata);
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    req_write   = 1'b0;
    req_size    = 2'd0;
    req_signed  = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    waitrequest = 1'b0;
    readdata    = '0;
    exp_rdata   = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_strobes", {read, write}, 0);
    check("rst_addr", address, 0);
    check("rst_wdata", writedata, 0);
    check("rst_be", byteenable, 0);
    check("rst_rdata", rdata, 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases
    run_txn(1'b0, 2'd2, 1'b0, 32'hBFC0_0000, 32'h0, 2, 32'h1234_5678);
    check("word_load_rdata", rdata, 32'h1234_5678);
    run_txn(1'b1, 2'd0, 1'b0, 32'h0000_0005, 32'h0000_00AB, 1, 32'h0);
    run_txn(1'b0, 2'd1, 1'b1, 32'h0000_0002, 32'h0, 0, 32'h8001_BEEF);
    check("half_signed", rdata, 32'hFFFF_8001);
    run_txn(1'b0, 2'd1, 1'b0, 32'h0000_0002, 32'h0, 0, 32'h8001_BEEF);
    check("half_unsigned", rdata, 32'h0000_8001);
    run_txn(1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0, 0, 32'hDEAD_BEEF);
    run_txn(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hCAFE_F00D, TO + 3, 32'h0);
    run_txn(1'b0, 2'd0, 1'b1, 32'h0000_0003, 32'h0, TO - 1, 32'h80FF_FFFF);
    run_txn(1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0, 0, 32'h0);

    // Reset in the second BUS cycle of a load
    start       = 1'b1;
    req_write   = 1'b0;
    req_size    = 2'd2;
    req_addr    = 32'h0000_0100;
    waitrequest = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rstbus_read1", read, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_rdata = '0;
    check("rstbus_read", read, 0);
    check("rstbus_write", write, 0);
    check("rstbus_busy", busy, 0);
    check("rstbus_done", done, 0);
    check("rstbus_err", err, 0);
    waitrequest = 1'b0;
    @(negedge clk);
    check("rstbus_done2", done, 0);
    run_txn(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 0, 32'h5A5A_1234);

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      int unsigned  r = $urandom_range(0, 9);
      logic [1:0]   sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      logic [31:0]  a = $urandom;
      int           nw;
      int unsigned  wsel = $urandom_range(0, 9);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      nw = (wsel < 7) ? int'($urandom_range(0, 3)) : (wsel < 9) ? int'(TO) - 1 : int'(TO) + 2;
      run_txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, nw, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
